// File: rtl/mdu_ctrl_pkg.sv
// Shared MDU definitions: op encodings, FSM states and op-class helpers.
// Optional multiply-accumulate ops are enabled by defining MDU_MADD_EN.
package mdu_ctrl_pkg;

  typedef enum logic [3:0] {
    OpNone  = 4'd0,
    OpMult  = 4'd1,
    OpMultu = 4'd2,
    OpDiv   = 4'd3,
    OpDivu  = 4'd4,
    OpMthi  = 4'd5,
    OpMtlo  = 4'd6,
    OpMadd  = 4'd7,
    OpMaddu = 4'd8,
    OpMsub  = 4'd9,
    OpMsubu = 4'd10
  } mdu_op_e;

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } mdu_state_e;

`ifdef MDU_MADD_EN
  localparam bit MaddEn = 1'b1;
`else
  localparam bit MaddEn = 1'b0;
`endif

  function automatic logic mdu_is_mac(logic [3:0] op);
    return MaddEn && (op inside {OpMadd, OpMaddu, OpMsub, OpMsubu});
  endfunction

  function automatic logic mdu_is_div(logic [3:0] op);
    return op inside {OpDiv, OpDivu};
  endfunction

  // Also used by the hazard unit to decide whether a D-stage op must wait.
  function automatic logic mdu_is_multi(logic [3:0] op);
    return (op inside {OpMult, OpMultu, OpDiv, OpDivu}) || mdu_is_mac(op);
  endfunction

endpackage

// File: rtl/mdu_ctrl_calc.sv
// Combinational MDU datapath: 64-bit product or {remainder, quotient} plus divide-by-zero flag.
module mdu_ctrl_calc
  import mdu_ctrl_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [31:0] i_rs,
  input  logic [31:0] i_rt,
  output logic [63:0] o_result,
  output logic        o_div0
);

  logic signed [63:0] w_rs_sx;
  logic signed [63:0] w_rt_sx;
  logic [63:0]        w_prod_s;
  logic [63:0]        w_prod_u;
  logic [31:0]        w_rt_safe;
  logic [31:0]        w_q_s;
  logic [31:0]        w_r_s;
  logic [31:0]        w_q_u;
  logic [31:0]        w_r_u;
  logic               w_ovf;

  assign w_rs_sx  = {{32{i_rs[31]}}, i_rs};
  assign w_rt_sx  = {{32{i_rt[31]}}, i_rt};
  assign w_prod_s = w_rs_sx * w_rt_sx;
  assign w_prod_u = {32'd0, i_rs} * {32'd0, i_rt};

  assign o_div0    = mdu_is_div(i_op) && (i_rt == 32'd0);
  // Divisor forced non-zero so the divider never sees 0; the result is discarded anyway.
  assign w_rt_safe = (i_rt == 32'd0) ? 32'd1 : i_rt;
  assign w_ovf     = (i_rs == 32'h8000_0000) && (i_rt == 32'hFFFF_FFFF);

  assign w_q_s = w_ovf ? 32'h8000_0000 : $unsigned($signed(i_rs) / $signed(w_rt_safe));
  assign w_r_s = w_ovf ? 32'd0 : $unsigned($signed(i_rs) % $signed(w_rt_safe));
  assign w_q_u = i_rs / w_rt_safe;
  assign w_r_u = i_rs % w_rt_safe;

  always_comb begin
    o_result = 64'd0;
    case (i_op)
      OpMult, OpMadd, OpMsub:    o_result = w_prod_s;
      OpMultu, OpMaddu, OpMsubu: o_result = w_prod_u;
      OpDiv:                     o_result = {w_r_s, w_q_s};
      OpDivu:                    o_result = {w_r_u, w_q_u};
      default:                   o_result = 64'd0;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// MDU controller: busy-window FSM, HI/LO registers and D-stage stall request.
// Define MDU_MADD_EN to accept madd/maddu/msub/msubu (accumulate into {HI,LO}).
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  MDUOP,
  input  logic [31:0] RsData,
  input  logic [31:0] RtData,
  input  logic        flush,
  input  logic        DUsesMdu,
  output logic        busy,
  output logic        MduStall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] MultN = 4'(MULT_CYCLES);
  localparam logic [3:0] DivN  = 4'(DIV_CYCLES);

  mdu_state_e  r_state;
  logic [3:0]  r_cnt;
  logic [3:0]  r_op;
  logic [63:0] r_result;
  logic        r_div0;
  logic        r_busy;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_go;
  logic        w_multi;
  logic [63:0] w_calc_result;
  logic        w_calc_div0;
  logic [63:0] w_commit;

  assign w_go    = start && !flush && (r_state == StIdle);
  assign w_multi = mdu_is_multi(MDUOP);

  mdu_ctrl_calc u_calc (
    .i_op     (MDUOP),
    .i_rs     (RsData),
    .i_rt     (RtData),
    .o_result (w_calc_result),
    .o_div0   (w_calc_div0)
  );

  // Accumulate ops read {HI,LO} at the commit edge, not at accept.
  always_comb begin
    w_commit = r_result;
    if (mdu_is_mac(r_op)) begin
      if (r_op inside {OpMsub, OpMsubu}) w_commit = {r_hi, r_lo} - r_result;
      else                               w_commit = {r_hi, r_lo} + r_result;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= StIdle;
      r_cnt    <= 4'd0;
      r_op     <= 4'd0;
      r_result <= 64'd0;
      r_div0   <= 1'b0;
      r_busy   <= 1'b0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_go) begin
            if (w_multi) begin
              r_state  <= StRun;
              r_busy   <= 1'b1;
              r_cnt    <= mdu_is_div(MDUOP) ? DivN : MultN;
              r_op     <= MDUOP;
              r_result <= w_calc_result;
              r_div0   <= w_calc_div0;
            end else if (MDUOP == OpMthi) begin
              r_hi <= RsData;
            end else if (MDUOP == OpMtlo) begin
              r_lo <= RsData;
            end
          end
        end
        StRun: begin
          if (r_cnt == 4'd1) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
            r_cnt   <= 4'd0;
            if (!r_div0) {r_hi, r_lo} <= w_commit;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign busy     = r_busy;
  assign HI       = r_hi;
  assign LO       = r_lo;
  assign MduStall = DUsesMdu && (r_busy || (start && w_multi && !flush));

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: vector table with scoreboard plus reset-mid-op sequence.
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  MDUOP;
  logic [31:0] RsData;
  logic [31:0] RtData;
  logic        flush;
  logic        DUsesMdu;
  logic        busy;
  logic        MduStall;
  logic [31:0] HI;
  logic [31:0] LO;

  mdu_ctrl #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .MDUOP    (MDUOP),
    .RsData   (RsData),
    .RtData   (RtData),
    .flush    (flush),
    .DUsesMdu (DUsesMdu),
    .busy     (busy),
    .MduStall (MduStall),
    .HI       (HI),
    .LO       (LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        fl;
    logic        du;
    int          cyc;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  typedef struct {
    string       name;
    int          cyc;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  vec_t vt[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  localparam int RstAt = 15;

  always @(posedge clk) begin
    if (!reset) assert (!(start && busy)) else $error("FAIL start_in_run: start=1 while busy=1");
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic add(input string name, input logic [3:0] op, input logic [31:0] rs,
                     input logic [31:0] rt, input logic fl, input logic du, input int cyc,
                     input logic [31:0] hi, input logic [31:0] lo);
    vec_t v;
    v.name = name; v.op = op; v.rs = rs; v.rt = rt; v.fl = fl; v.du = du;
    v.cyc = cyc; v.hi = hi; v.lo = lo;
    vt.push_back(v);
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    int   cnt;
    bit   done;
    @(negedge clk);
    start = 1'b1; MDUOP = v.op; RsData = v.rs; RtData = v.rt; flush = v.fl; DUsesMdu = v.du;
    #1 chk1({v.name, ":stall_start"}, MduStall, v.du && (v.cyc > 0));
    e.name = v.name; e.cyc = v.cyc; e.hi = v.hi; e.lo = v.lo;
    sb.push_back(e);
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0;
    cnt  = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (!busy) begin
        done = 1'b1;
      end else begin
        cnt++;
        chk1({v.name, ":stall_busy"}, MduStall, v.du);
        // Operands must already be latched; scramble them during the busy window.
        RsData = $urandom;
        RtData = $urandom;
        if (cnt > 40) begin
          n_cmp++; n_bad++;
          $display("FAIL %s:timeout busy still %b after %0d cycles", v.name, busy, cnt);
          done = 1'b1;
        end
      end
    end
    e = sb.pop_front();
    chk_int({e.name, ":busy_cycles"}, cnt, e.cyc);
    chk32({e.name, ":HI"}, HI, e.hi);
    chk32({e.name, ":LO"}, LO, e.lo);
    chk1({e.name, ":stall_done"}, MduStall, 1'b0);
    DUsesMdu = 1'b0;
  endtask

  task automatic reset_mid_op();
    @(negedge clk);
    start = 1'b1; MDUOP = OpDiv; RsData = 32'd100; RtData = 32'd7; flush = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    chk1("rst_mid:busy_before", busy, 1'b1);
    reset = 1'b1;
    #1;
    chk1("rst_mid:busy", busy, 1'b0);
    chk32("rst_mid:HI", HI, 32'd0);
    chk32("rst_mid:LO", LO, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    chk1("rst_mid:busy_after", busy, 1'b0);
    chk32("rst_mid:HI_after", HI, 32'd0);
    chk32("rst_mid:LO_after", LO, 32'd0);
  endtask

  initial begin
    add("mult_neg",   OpMult,  32'hFFFF_FFFE, 32'd3, 1'b0, 1'b1, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    add("multu",      OpMultu, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0, 5, 32'h0000_0002, 32'hFFFF_FFFA);
    add("div_neg",    OpDiv,   32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    add("divu",       OpDivu,  32'd7, 32'd2, 1'b0, 1'b0, 10, 32'd1, 32'd3);
    add("div_ovf",    OpDiv,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 10, 32'd0, 32'h8000_0000);
    add("mthi",       OpMthi,  32'h1111_1111, 32'd0, 1'b0, 1'b1, 0, 32'h1111_1111, 32'h8000_0000);
    add("mtlo",       OpMtlo,  32'h2222_2222, 32'd0, 1'b0, 1'b0, 0, 32'h1111_1111, 32'h2222_2222);
    add("divu_zero",  OpDivu,  32'd7, 32'd0, 1'b0, 1'b1, 10, 32'h1111_1111, 32'h2222_2222);
    add("mult_flush", OpMult,  32'd5, 32'd5, 1'b1, 1'b1, 0, 32'h1111_1111, 32'h2222_2222);
    add("mthi_flush", OpMthi,  32'h0000_ABCD, 32'd0, 1'b1, 1'b0, 0, 32'h1111_1111, 32'h2222_2222);
    add("mthi_abcd",  OpMthi,  32'h0000_ABCD, 32'd0, 1'b0, 1'b0, 0, 32'h0000_ABCD, 32'h2222_2222);
    add("op_none",    OpNone,  32'h1234_5678, 32'd9, 1'b0, 1'b1, 0, 32'h0000_ABCD, 32'h2222_2222);
    add("op_12",      4'd12,   32'h1234_5678, 32'd9, 1'b0, 1'b0, 0, 32'h0000_ABCD, 32'h2222_2222);
    add("mult_max",   OpMult,  32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 1'b0, 5, 32'h3FFF_FFFF,
        32'h0000_0001);
    add("div_negdiv", OpDiv,   32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0, 10, 32'd1, 32'hFFFF_FFFD);
    add("mult_post",  OpMult,  32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    add("mtlo_ones",  OpMtlo,  32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    add("mthi_zero",  OpMthi,  32'd0, 32'd0, 1'b0, 1'b0, 0, 32'd0, 32'hFFFF_FFFF);
`ifdef MDU_MADD_EN
    add("maddu",      OpMaddu, 32'd1, 32'd1, 1'b0, 1'b0, 5, 32'd1, 32'd0);
    add("msub",       OpMsub,  32'd2, 32'd3, 1'b0, 1'b0, 5, 32'd0, 32'hFFFF_FFFA);
`else
    add("maddu_off",  OpMaddu, 32'd1, 32'd1, 1'b0, 1'b1, 0, 32'd0, 32'hFFFF_FFFF);
    add("msub_off",   OpMsub,  32'd2, 32'd3, 1'b0, 1'b0, 0, 32'd0, 32'hFFFF_FFFF);
`endif

    reset = 1'b1; start = 1'b0; MDUOP = 4'd0; RsData = 32'd0; RtData = 32'd0;
    flush = 1'b0; DUsesMdu = 1'b1;
    repeat (2) @(negedge clk);
    chk1("reset:busy", busy, 1'b0);
    chk1("reset:stall", MduStall, 1'b0);
    chk32("reset:HI", HI, 32'd0);
    chk32("reset:LO", LO, 32'd0);
    reset = 1'b0;
    DUsesMdu = 1'b0;

    foreach (vt[i]) begin
      if (i == RstAt) reset_mid_op();
      run_vec(vt[i]);
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide unit controller with the HI/LO registers, sitting in the E stage beside the ALU.
- Takes forwarded rs/rt operands (post forwarding mux), sequences a fixed-latency mult/div busy window, and commits results to HI/LO.
- Produces the stall request that the hazard logic uses to freeze F/D while a D-stage MDU instruction waits.
- Handles flush from the exception/interrupt path so a cancelled E-stage instruction never starts or writes HI/LO.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu/madd-family; legal range 1..15.
- DIV_CYCLES, 10, busy cycles for div/divu; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  E-stage instruction is an MDU op (qualifies MDUOP)
- MDUOP  in  4  op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu, 9 msub, 10 msubu, 11-15 none
- RsData  in  32  forwarded rs operand
- RtData  in  32  forwarded rt operand
- flush  in  1  E-stage instruction cancelled (exception/interrupt) this cycle
- DUsesMdu  in  1  D-stage instruction is any MDU op, including mfhi/mflo
- busy  out  1  multi-cycle operation in flight
- MduStall  out  1  DUsesMdu & (busy | (start & MDUOP is multi-cycle & ~flush))
- HI  out  32  HI register, feeds the mfhi path in the E-to-GRF data mux
- LO  out  32  LO register, feeds the mflo path

Behaviour:
- Reset values: state IDLE, HI=0, LO=0, busy=0, counter=0, result latches=0. Asynchronous reset overrides everything, including an op mid-flight, which is discarded.
- States:
  - IDLE → RUN on accepted multi-cycle start.
  - RUN → IDLE when the counter reaches 1 at a clock edge; HI/LO commit on that same edge.
- Accept rule: start & ~flush & state==IDLE. A start while in RUN is ignored, since the hazard unit guarantees it cannot occur; the bench flags it as an assertion.
- Operands are latched at the accept edge, so later changes to RsData/RtData have no effect.
- Arithmetic is computed at accept into a 64-bit result latch:
  - mult: signed 32x32 → 64; HI=[63:32], LO=[31:0].
  - multu: unsigned 32x32 → 64.
  - div: signed; LO=quotient truncated toward zero; HI=remainder with the dividend's sign. 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - divu: unsigned quotient/remainder.
  - Divide by zero (RtData==0): the busy window still runs; HI/LO are left unchanged.
- Latency: accept at edge T. busy=1 for exactly N cycles after T, where N=MULT_CYCLES or DIV_CYCLES. New HI/LO are visible in the same cycle busy drops.
- mthi/mtlo: single-cycle, no busy. The write takes effect at the accept edge if state==IDLE and ~flush; ignored in RUN.
- flush: blocks accept and mthi/mtlo writes in that cycle. It does not abort an op already in RUN, because that instruction has already passed E.
- Counter is 4 bits, loaded with N at accept and decremented each cycle in RUN. There is no wrap: it stops at commit.
- A 64-bit product is the only wide arithmetic; the division result is 32+32 bits.

Optional Feature:
- Macro: MDU_MADD_EN.
- When defined, ops 7-10 are accepted with MULT_CYCLES latency:
  - madd: {HI,LO} += signed product.
  - maddu: {HI,LO} += unsigned product.
  - msub / msubu: the same with subtraction.
  - All are modulo 2^64. The accumulator base is {HI,LO} sampled at the commit edge, so an mthi/mtlo cannot intervene.
- When undefined, ops 7-10 behave as op 0: no accept, no busy, no write.

Decomposition:
- Shared include mdu_defs:
  - MDUOP encodings 0-15.
  - State encodings IDLE/RUN.
  - Helper constant for "op is multi-cycle"; the hazard unit shares it to derive DUsesMdu.
- One sub-module, mdu_calc: combinational.
  - Inputs: latched operands and op; output: 64-bit result plus a divide-by-zero flag.
  - mdu_ctrl keeps the FSM, counter, HI/LO and stall logic.

Test Plan:
- mult: RsData=0xFFFFFFFE (-2), RtData=3, start at T → busy high T+1..T+5; then HI=0xFFFFFFFF, LO=0xFFFFFFFA; multu with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- div: RsData=-7, RtData=2 → after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. Separately, divu 7/0 → HI/LO keep their prior values 0x11111111/0x22222222 and busy still lasts 10 cycles.
- Stall: DUsesMdu=1 during a mult start → MduStall=1 from the start cycle through the last busy cycle and 0 in the commit-visible cycle. With DUsesMdu=0, MduStall stays 0.
- Flush: start=1 MDUOP=1 with flush=1 → busy stays 0, HI/LO unchanged. mthi RsData=0xABCD with flush=1 → HI unchanged. Without flush → HI=0xABCD next cycle.
- Reset mid-op: assert reset at the 3rd busy cycle of a div → busy=0, HI=LO=0 immediately (asynchronous). After release a new mult is accepted normally.
- MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, maddu 1*1 → HI=1, LO=0. Without the macro the same op leaves HI=0, LO=0xFFFFFFFF and busy=0.
